// File: rtl/multi_tick_gen.sv
// Shared free-running prescaler feeding NUM_CH independent tick channels,
// each with a programmable period (in base ticks) and periodic/one-shot mode.
`timescale 1ns/1ps
module multi_tick_gen #(
    parameter int CLK_FREQ_HZ    = 100_000_000,
    parameter int BASE_PERIOD_US = 1000,
    parameter int NUM_CH         = 4,
    parameter int PERIOD_W       = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            en,
    input  logic [NUM_CH-1:0]            oneshot,
    input  logic [NUM_CH-1:0]            start,
    input  logic [NUM_CH*PERIOD_W-1:0]   period,
    output logic                         base_tick,
    output logic [NUM_CH-1:0]            tick,
    output logic [NUM_CH-1:0]            busy
);

    localparam int PRESC   = CLK_FREQ_HZ / 1_000_000 * BASE_PERIOD_US;
    localparam int PRESC_W = (PRESC < 2) ? 1 : $clog2(PRESC);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC - 1);

    if (PRESC < 2) begin : g_bad_presc
        $error("multi_tick_gen: prescale ratio must be at least 2");
    end
    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("multi_tick_gen: NUM_CH must lie in 1..16");
    end

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    logic [PRESC_W-1:0] presc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q   <= '0;
            base_tick <= 1'b0;
        end else begin
            base_tick <= (presc_q == PRESC_LAST);
            presc_q   <= (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t              state_q, state_n;
        logic [PERIOD_W-1:0] count_q, count_n;
        logic [PERIOD_W-1:0] ch_period;
        logic                tick_q, tick_n;

        assign ch_period = period[i*PERIOD_W +: PERIOD_W];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= IDLE;
                count_q <= '0;
                tick_q  <= 1'b0;
            end else begin
                state_q <= state_n;
                count_q <= count_n;
                tick_q  <= tick_n;
            end
        end

        // Restart outranks a same-cycle base_tick; a zero period always parks the channel.
        always_comb begin
            state_n = state_q;
            count_n = count_q;
            tick_n  = 1'b0;
            if (!en[i]) begin
                state_n = IDLE;
                count_n = '0;
            end else if (state_q == IDLE) begin
                if (start[i] && (ch_period != '0)) begin
                    state_n = RUN;
                    count_n = ch_period;
                end
            end else if (start[i]) begin
                if (ch_period == '0) begin
                    state_n = IDLE;
                    count_n = '0;
                end else begin
                    count_n = ch_period;
                end
            end else if (base_tick) begin
                if (count_q > PERIOD_W'(1)) begin
                    count_n = count_q - 1'b1;
                end else begin
                    tick_n = 1'b1;
                    if (oneshot[i] || (ch_period == '0)) begin
                        state_n = IDLE;
                        count_n = '0;
                    end else begin
                        count_n = ch_period;
                    end
                end
            end
        end

        assign tick[i] = tick_q;
        assign busy[i] = (state_q == RUN);
    end

endmodule

// File: tb/tb_multi_tick_gen.sv
// Directed bench for multi_tick_gen with PRESC=4, four 8-bit channels.
`timescale 1ns/1ps
module tb_multi_tick_gen;

    logic        clk;
    logic        reset;
    logic [3:0]  en;
    logic [3:0]  oneshot;
    logic [3:0]  start;
    logic [31:0] period;
    logic        base_tick;
    logic [3:0]  tick;
    logic [3:0]  busy;

    int n_assert;
    int n_fail;
    int cyc;
    int c0, c1, c2, c3, c4;

    multi_tick_gen #(
        .CLK_FREQ_HZ   (4_000_000),
        .BASE_PERIOD_US(1),
        .NUM_CH        (4),
        .PERIOD_W      (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .oneshot  (oneshot),
        .start    (start),
        .period   (period),
        .base_tick(base_tick),
        .tick     (tick),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_phase0();
        while ((cyc % 4) != 0) step();
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        cyc      = 0;
        reset    = 1'b0;
        en       = '0;
        oneshot  = '0;
        start    = '0;
        period   = '0;

        repeat (3) @(posedge clk);
        #1;
        chk1("rst_base_tick", base_tick, 1'b0);
        chk4("rst_tick", tick, 4'h0);
        chk4("rst_busy", busy, 4'h0);
        reset = 1'b1;

        // Prescaler alone: base_tick in cycles 4, 8, 12
        repeat (12) begin
            step();
            chk1("presc_base_tick", base_tick, (cyc == 4 || cyc == 8 || cyc == 12));
            chk4("idle_tick", tick, 4'h0);
            chk4("idle_busy", busy, 4'h0);
        end

        // ch0 periodic, period 3 -> ticks every 12 clocks
        wait_phase0();
        c0 = cyc;
        en[0] = 1'b1; oneshot[0] = 1'b0; period[7:0] = 8'd3; start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        chk1("a_busy_start", busy[0], 1'b1);
        repeat (36) begin
            step();
            chk1("a_tick0", tick[0], (cyc == c0+13 || cyc == c0+25 || cyc == c0+37));
            chk1("a_busy0", busy[0], 1'b1);
        end
        repeat (6) step();
        en[0] = 1'b0;
        step();
        chk1("a_en_drop_busy0", busy[0], 1'b0);
        repeat (12) begin
            step();
            chk1("a_en_drop_tick0", tick[0], 1'b0);
            chk1("a_en_drop_busy0_hold", busy[0], 1'b0);
        end

        // ch1 one-shot, period 2
        wait_phase0();
        c1 = cyc;
        en[1] = 1'b1; oneshot[1] = 1'b1; period[15:8] = 8'd2; start[1] = 1'b1;
        step();
        start[1] = 1'b0;
        chk1("b_busy_start", busy[1], 1'b1);
        repeat (8) begin
            step();
            chk1("b_tick1", tick[1], (cyc == c1+9));
            chk1("b_busy1", busy[1], (cyc < c1+9));
        end
        repeat (100) begin
            step();
            chk1("b_no_more_tick1", tick[1], 1'b0);
            chk1("b_idle_busy1", busy[1], 1'b0);
        end

        // ch1 start with period 0 is ignored
        period[15:8] = 8'd0; oneshot[1] = 1'b0; start[1] = 1'b1;
        step();
        start[1] = 1'b0;
        chk1("z_busy1", busy[1], 1'b0);
        repeat (12) begin
            step();
            chk1("z_tick1", tick[1], 1'b0);
            chk1("z_busy1_hold", busy[1], 1'b0);
        end
        en[1] = 1'b0;

        // ch2 period 5, changed to 2 mid-count
        wait_phase0();
        c2 = cyc;
        en[2] = 1'b1; oneshot[2] = 1'b0; period[23:16] = 8'd5; start[2] = 1'b1;
        step();
        start[2] = 1'b0;
        chk1("c_busy_start", busy[2], 1'b1);
        repeat (56) begin
            step();
            if (cyc == c2+30) period[23:16] = 8'd2;
            chk1("c_tick2", tick[2],
                 (cyc == c2+21 || cyc == c2+41 || cyc == c2+49 || cyc == c2+57));
        end
        en[2] = 1'b0;
        step();

        // ch3 restart on a base_tick cycle with count==1
        wait_phase0();
        c3 = cyc;
        en[3] = 1'b1; oneshot[3] = 1'b0; period[31:24] = 8'd2; start[3] = 1'b1;
        step();
        start[3] = 1'b0;
        repeat (16) begin
            step();
            start[3] = (cyc == c3+8);
            chk1("d_tick3", tick[3], (cyc == c3+17));
            chk1("d_busy3", busy[3], 1'b1);
        end
        start[3] = 1'b0;
        en[3] = 1'b0;
        step();

        // All channels, period 1: simultaneous ticks after every base_tick
        wait_phase0();
        c4 = cyc;
        en = 4'hF; oneshot = 4'h0; period = {4{8'd1}}; start = 4'hF;
        step();
        start = 4'h0;
        chk4("e_busy_start", busy, 4'hF);
        chk4("e_tick_first", tick, 4'h0);
        repeat (16) begin
            step();
            chk4("e_tick_all", tick, (((cyc - c4) % 4) == 1) ? 4'hF : 4'h0);
            chk4("e_busy_all", busy, 4'hF);
        end

        // Asynchronous reset mid-run, checked before the next clock edge
        reset = 1'b0;
        #1;
        chk4("r_async_tick", tick, 4'h0);
        chk4("r_async_busy", busy, 4'h0);
        chk1("r_async_base_tick", base_tick, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_tick_gen.md
Name: multi_tick_gen

Overview:
- Next-generation tick generator: one shared free-running prescaler plus NUM_CH independent tick channels.
- Each channel has a runtime-programmable period, counted in base ticks, and runs in periodic or one-shot mode.
- Each channel has its own enable, start and busy.
- Feeds timers, debouncers and display refresh logic that currently each instantiate a fixed-period tick block.

Parameters:
- CLK_FREQ_HZ, 100_000_000, system clock frequency in Hz.
- BASE_PERIOD_US, 1000, base tick period in microseconds. PRESC = CLK_FREQ_HZ/1_000_000*BASE_PERIOD_US; elaboration error if PRESC < 2.
- NUM_CH, 4, number of tick channels (1..16).
- PERIOD_W, 16, width of each channel's period field, in base ticks.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  NUM_CH  per-channel enable, level.
- oneshot  in  NUM_CH  per-channel mode: 1 = one-shot, 0 = periodic. Sampled at start and at each reload.
- start  in  NUM_CH  per-channel start/restart pulse, 1 cycle.
- period  in  NUM_CH*PERIOD_W  per-channel period in base ticks. Channel i uses bits [i*PERIOD_W +: PERIOD_W].
- base_tick  out  1  1-cycle pulse every PRESC clocks.
- tick  out  NUM_CH  per-channel 1-cycle tick pulse.
- busy  out  NUM_CH  channel is in RUN.

Behaviour:
- Reset (reset=0, asynchronous):
  - prescaler counter=0, base_tick=0;
  - every channel in IDLE, count=0, tick=0, busy=0.
- Prescaler:
  - Counter width $clog2(PRESC). Counts 0..PRESC-1 and wraps; free-running, independent of en.
  - base_tick is registered: high for the one cycle following the clock in which the counter equals PRESC-1.
  - After reset release, the first base_tick is high during cycle PRESC (cycles numbered from 1).
- Channel FSM, two states, IDLE and RUN:
  - IDLE -> RUN: en=1 and start=1 and period!=0. Load count=period; busy=1 from the next cycle.
  - IDLE with start=1 and period==0: ignored, stays IDLE, no tick.
  - RUN, base_tick=1, count>1: count <= count-1.
  - RUN, base_tick=1, count==1: tick=1 on the next cycle. Then:
    - periodic (oneshot=0): reload count=period as sampled that cycle. If that period==0, go to IDLE.
    - one-shot (oneshot=1): go to IDLE; busy=0 on the same cycle tick=1.
  - RUN, start=1 (restart): reload count=period. Start takes priority over a same-cycle base_tick, so no decrement and no tick that cycle.
  - Any state, en=0: go to IDLE next cycle, count=0. A tick already registered this cycle still completes; no new tick is issued.
  - en and start in the same cycle as en's rising edge: start is honoured.
- Timing:
  - The first tick follows the period-th base_tick after start, so the start-to-tick delay lies in ((period-1)*PRESC, period*PRESC] clocks.
  - The phase offset comes from the shared prescaler and is intended.
  - Periodic ticks are exactly period*PRESC clocks apart while period is constant.
- Other rules:
  - Live period changes in RUN take effect only at the next reload or restart.
  - tick is never high on two consecutive cycles per channel.
  - All outputs are registered; no combinational path from inputs to outputs.
  - Channels are fully independent; simultaneous ticks on several channels are legal.
  - Count arithmetic is PERIOD_W-bit unsigned; maximum period 2^PERIOD_W-1.

Test Plan:
- Bench parameters: CLK_FREQ_HZ=4_000_000, BASE_PERIOD_US=1 (PRESC=4), NUM_CH=4, PERIOD_W=8.
- Reset release, no start -> base_tick high at cycles 4, 8, 12; tick=0 and busy=0 on all channels.
- ch0: en=1, oneshot=0, period=3, start -> tick every 12 clocks, exactly; busy held 1.
- ch1: oneshot=1, period=2 -> exactly one tick, 5..8 clocks after start, with busy falling on that cycle; no further ticks over 100 cycles.
- ch2: period=5 running, period changed to 2 mid-count -> next tick still 5 base ticks after the previous one, then every 2 base ticks.
- ch3: restart -> start pulsed again on a base_tick cycle with count==1: no tick that cycle, count reloaded.
- ch0: en dropped -> en=0 mid-run: no tick, busy=0 next cycle.
- Corner cases:
  - start with period=0 -> stays IDLE.
  - Reset asserted mid-run -> all outputs 0 immediately (asynchronous), without waiting for a clock edge.
- All four channels with period=1 -> four simultaneous ticks on every base_tick.
